// File: rtl/burst_writer_pkg.sv
// burst_writer_pkg: FSM state encoding and default sizing shared by burst_writer
package burst_writer_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 1024;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t BURST = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/burst_writer.sv
// burst_writer: writes a length-bounded stream burst to consecutive memory addresses; BURST_WRITER_CHECKSUM_EN adds a checksum output
module burst_writer
    import burst_writer_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int Depth = DEFAULT_DEPTH,
    localparam int AW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    startAddr,
    input  logic [AW:0]      len,
    input  logic             abort,
    input  logic             inValid,
    input  logic [Width-1:0] inData,
    output logic             inReady,
    output logic             wrEn,
    output logic [AW-1:0]    wrAddr,
    output logic [Width-1:0] wrData,
    output logic             busy,
    output logic             done
`ifdef BURST_WRITER_CHECKSUM_EN
    ,
    output logic [Width-1:0] checksum
`endif
);

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;
    logic          accept;
    logic          last;
    logic [AW-1:0] addr_next;

    assign inReady   = (state == BURST) && !abort;
    assign accept    = inValid && inReady;
    assign busy      = state != IDLE;
    assign last      = remaining == (AW+1)'(1);
    assign addr_next = (addr == AW'(Depth - 1)) ? '0 : addr + AW'(1);

    // Burst sequencing plus a one-cycle-latency registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            done      <= 1'b0;
        end else begin
            wrEn <= accept;
            done <= 1'b0;
            if (accept) begin
                wrAddr    <= addr;
                wrData    <= inData;
                addr      <= addr_next;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        addr      <= startAddr;
                        remaining <= len;
                        state     <= BURST;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                BURST: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept && last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURST_WRITER_CHECKSUM_EN
    // Running sum of accepted beats, cleared when a start is taken in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + inData;
        end
    end
`endif

endmodule
